// File: rtl/uart_tx_frame.sv
// UART transmitter with configurable data width, parity and stop bits.
// A one-entry holding register lets consecutive frames leave with no idle gap.
module uart_tx_frame #(
    parameter int clk_hz      = 50_000_000,
    parameter int baud_rate   = 115_200,
    parameter int data_bits   = 8,
    parameter int parity_mode = 0,
    parameter int stop_bits   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [data_bits-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 tx_busy
);

    localparam int clks_per_bit = clk_hz / baud_rate;
    localparam int tmr_w = ($clog2(clks_per_bit) > 1) ? $clog2(clks_per_bit) : 1;
    localparam int idx_w = $clog2((data_bits > stop_bits) ? data_bits : stop_bits);
    localparam logic [tmr_w-1:0] tmr_last  = tmr_w'(clks_per_bit - 1);
    localparam logic [idx_w-1:0] data_last = idx_w'(data_bits - 1);
    localparam logic [idx_w-1:0] stop_last = idx_w'(stop_bits - 1);

    if (clks_per_bit < 2) begin : g_bad_rate
        $error("uart_tx_frame: clk_hz / baud_rate must be at least 2");
    end
    if (data_bits < 5 || data_bits > 9) begin : g_bad_width
        $error("uart_tx_frame: data_bits must be in 5..9");
    end
    if (parity_mode < 0 || parity_mode > 2) begin : g_bad_parity
        $error("uart_tx_frame: parity_mode must be 0, 1 or 2");
    end
    if (stop_bits < 1 || stop_bits > 2) begin : g_bad_stop
        $error("uart_tx_frame: stop_bits must be 1 or 2");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state;
    logic [tmr_w-1:0]       timer;
    logic [idx_w-1:0]       bit_idx;
    logic [data_bits-1:0]   shift;
    logic [data_bits-1:0]   hold_data;
    logic                   hold_full;
    logic                   parity_bit;
    logic                   accept;
    logic                   bit_done;

    function automatic logic parity_of(input logic [data_bits-1:0] w);
        return (parity_mode == 1) ? ~^w : ^w;
    endfunction

    // NOTE: tx_ready is a pure register decode, so accept never forms a loop with tx_valid.
    assign tx_ready = !hold_full;
    assign accept   = tx_valid && !hold_full;
    assign bit_done = (timer == tmr_last);

    // NOTE: every register here uses <= so all branches see the pre-edge values consistently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            hold_data  <= '0;
            hold_full  <= 1'b0;
            parity_bit <= 1'b0;
            txd        <= 1'b1;
            tx_busy    <= 1'b0;
        end else begin
            if (state != IDLE) begin
                timer <= bit_done ? '0 : timer + 1'b1;
            end

            case (state)
                IDLE: begin
                    timer   <= '0;
                    bit_idx <= '0;
                    if (accept) begin
                        shift      <= tx_data;
                        parity_bit <= parity_of(tx_data);
                        state      <= START;
                        txd        <= 1'b0;
                        tx_busy    <= 1'b1;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state <= DATA;
                        txd   <= shift[0];
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_idx == data_last) begin
                            bit_idx <= '0;
                            if (parity_mode != 0) begin
                                state <= PARITY;
                                txd   <= parity_bit;
                            end else begin
                                state <= STOP;
                                txd   <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= shift >> 1;
                            txd     <= shift[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        state <= STOP;
                        txd   <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        if (bit_idx == stop_last) begin
                            bit_idx <= '0;
                            if (hold_full) begin
                                // Chain straight into the next start bit.
                                shift      <= hold_data;
                                parity_bit <= parity_of(hold_data);
                                hold_full  <= 1'b0;
                                state      <= START;
                                txd        <= 1'b0;
                            end else begin
                                state   <= IDLE;
                                tx_busy <= 1'b0;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    txd     <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase

            // Placed last so a word accepted on a transfer edge still lands in holding.
            if (accept && state != IDLE) begin
                hold_data <= tx_data;
                hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: five parameterisations, a bit-level
// scoreboard filled at drive time and drained cycle by cycle from txd.
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] valid_r = '0;
    logic [4:0] txd_w;
    logic [4:0] busy_w;
    logic [4:0] ready_w;
    logic [8:0] data_r [5];

    int n_pass  = 0;
    int n_total = 0;
    bit exp_q [$];

    int cpb_c [5] = '{4, 4, 4, 4, 434};
    int db_c  [5] = '{8, 8, 8, 7, 8};
    int pm_c  [5] = '{0, 2, 1, 0, 0};
    int sb_c  [5] = '{1, 1, 1, 2, 1};

    always #5 clk = ~clk;

    uart_tx_frame #(.clk_hz(16), .baud_rate(4), .data_bits(8), .parity_mode(0), .stop_bits(1)) u_8n1 (
        .clk(clk), .rst(rst), .tx_valid(valid_r[0]), .tx_data(data_r[0][7:0]),
        .tx_ready(ready_w[0]), .txd(txd_w[0]), .tx_busy(busy_w[0]));
    uart_tx_frame #(.clk_hz(16), .baud_rate(4), .data_bits(8), .parity_mode(2), .stop_bits(1)) u_8e1 (
        .clk(clk), .rst(rst), .tx_valid(valid_r[1]), .tx_data(data_r[1][7:0]),
        .tx_ready(ready_w[1]), .txd(txd_w[1]), .tx_busy(busy_w[1]));
    uart_tx_frame #(.clk_hz(16), .baud_rate(4), .data_bits(8), .parity_mode(1), .stop_bits(1)) u_8o1 (
        .clk(clk), .rst(rst), .tx_valid(valid_r[2]), .tx_data(data_r[2][7:0]),
        .tx_ready(ready_w[2]), .txd(txd_w[2]), .tx_busy(busy_w[2]));
    uart_tx_frame #(.clk_hz(16), .baud_rate(4), .data_bits(7), .parity_mode(0), .stop_bits(2)) u_7n2 (
        .clk(clk), .rst(rst), .tx_valid(valid_r[3]), .tx_data(data_r[3][6:0]),
        .tx_ready(ready_w[3]), .txd(txd_w[3]), .tx_busy(busy_w[3]));
    uart_tx_frame u_default (
        .clk(clk), .rst(rst), .tx_valid(valid_r[4]), .tx_data(data_r[4][7:0]),
        .tx_ready(ready_w[4]), .txd(txd_w[4]), .tx_busy(busy_w[4]));

    // Expected line levels for one frame, one entry per bit period.
    function automatic void push_frame(input int sel, input logic [8:0] w);
        int ones = 0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < db_c[sel]; i++) begin
            exp_q.push_back(w[i]);
            ones += int'(w[i]);
        end
        if (pm_c[sel] == 1) exp_q.push_back((ones % 2) == 0);
        if (pm_c[sel] == 2) exp_q.push_back((ones % 2) == 1);
        for (int i = 0; i < sb_c[sel]; i++) exp_q.push_back(1'b1);
    endfunction

    task automatic send(input int sel, input logic [8:0] w);
        int g = 0;
        @(negedge clk);
        while (ready_w[sel] !== 1'b1 && g < 500) begin
            @(negedge clk);
            g++;
        end
        n_total++;
        if (ready_w[sel] !== 1'b1) begin
            $display("FAIL send_ready sel=%0d: tx_ready=%b, required 1 within 500 cycles", sel, ready_w[sel]);
            return;
        end
        n_pass++;
        valid_r[sel] = 1'b1;
        data_r[sel]  = w;
        push_frame(sel, w);
        @(negedge clk);
        valid_r[sel] = 1'b0;
    endtask

    // Waits for a start bit, then checks txd/tx_busy every cycle of nframes frames.
    task automatic monitor(input int sel, input int nframes);
        int   guard = 0;
        int   nb;
        bit   exp_b;
        bit   ok;
        logic bad_txd;
        logic bad_busy;
        nb = 1 + db_c[sel] + ((pm_c[sel] != 0) ? 1 : 0) + sb_c[sel];
        while (txd_w[sel] === 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        n_total++;
        if (txd_w[sel] !== 1'b0) begin
            $display("FAIL start_detect sel=%0d: txd=%b, required 0 within 200 cycles", sel, txd_w[sel]);
            return;
        end
        n_pass++;
        for (int f = 0; f < nframes; f++) begin
            for (int b = 0; b < nb; b++) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL scoreboard_empty sel=%0d frame%0d bit%0d: queue size 0, required >0", sel, f, b);
                    return;
                end
                n_total--;
                exp_b    = exp_q.pop_front();
                ok       = 1'b1;
                bad_txd  = 1'b0;
                bad_busy = 1'b0;
                for (int c = 0; c < cpb_c[sel]; c++) begin
                    if (ok && (txd_w[sel] !== exp_b || busy_w[sel] !== 1'b1)) begin
                        ok       = 1'b0;
                        bad_txd  = txd_w[sel];
                        bad_busy = busy_w[sel];
                    end
                    @(negedge clk);
                end
                n_total++;
                if (ok) n_pass++;
                else $display("FAIL frame%0d_bit%0d sel=%0d: txd=%b busy=%b, required txd=%b busy=1",
                              f, b, sel, bad_txd, bad_busy, exp_b);
            end
        end
        n_total++;
        if (txd_w[sel] !== 1'b1 || busy_w[sel] !== 1'b0)
            $display("FAIL frame_end sel=%0d: txd=%b busy=%b, required txd=1 busy=0", sel, txd_w[sel], busy_w[sel]);
        else n_pass++;
    endtask

    task automatic test_reset();
        bit ok = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if (txd_w !== 5'h1f) $display("FAIL reset_txd: txd=%b, required 11111", txd_w);
        else n_pass++;
        n_total++;
        if (ready_w !== 5'h1f) $display("FAIL reset_ready: tx_ready=%b, required 11111", ready_w);
        else n_pass++;
        n_total++;
        if (busy_w !== 5'h00) $display("FAIL reset_busy: tx_busy=%b, required 00000", busy_w);
        else n_pass++;
        for (int i = 0; i < 100; i++) begin
            if (txd_w !== 5'h1f || busy_w !== 5'h00) ok = 1'b0;
            @(negedge clk);
        end
        n_total++;
        if (!ok) $display("FAIL idle_hold: txd=%b busy=%b, required txd=11111 busy=00000 for 100 cycles", txd_w, busy_w);
        else n_pass++;
    endtask

    task automatic test_8n1();
        fork
            send(0, 9'h0a5);
            monitor(0, 1);
        join
    endtask

    task automatic test_parity();
        fork
            send(1, 9'h0a5);
            monitor(1, 1);
        join
        fork
            send(2, 9'h0a5);
            monitor(2, 1);
        join
        fork
            send(2, 9'h007);
            monitor(2, 1);
        join
    endtask

    task automatic test_back_to_back();
        int g = 0;
        fork
            begin
                send(3, 9'h055);
                repeat (12) @(negedge clk);
                n_total++;
                if (ready_w[3] !== 1'b1) $display("FAIL b2b_ready_before_hold: tx_ready=%b, required 1", ready_w[3]);
                else n_pass++;
                valid_r[3] = 1'b1;
                data_r[3]  = 9'h02a;
                push_frame(3, 9'h02a);
                @(negedge clk);
                n_total++;
                if (ready_w[3] !== 1'b0) $display("FAIL b2b_ready_held: tx_ready=%b, required 0", ready_w[3]);
                else n_pass++;
                data_r[3] = 9'h011;
                push_frame(3, 9'h011);
                while (ready_w[3] !== 1'b1 && g < 100) begin
                    @(negedge clk);
                    g++;
                end
                n_total++;
                if (g != 27) $display("FAIL b2b_ready_rise: waited %0d cycles, required 27", g);
                else n_pass++;
                @(negedge clk);
                valid_r[3] = 1'b0;
                n_total++;
                if (ready_w[3] !== 1'b0) $display("FAIL b2b_third_accept: tx_ready=%b, required 0", ready_w[3]);
                else n_pass++;
            end
            monitor(3, 3);
        join
    endtask

    task automatic test_reset_mid_frame();
        bit ok = 1'b1;
        send(0, 9'h0a5);
        repeat (4) @(negedge clk);
        valid_r[0] = 1'b1;
        data_r[0]  = 9'h03c;
        @(negedge clk);
        valid_r[0] = 1'b0;
        n_total++;
        if (ready_w[0] !== 1'b0) $display("FAIL mid_hold_full: tx_ready=%b, required 0", ready_w[0]);
        else n_pass++;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_total++;
        if (txd_w[0] !== 1'b1 || ready_w[0] !== 1'b1 || busy_w[0] !== 1'b0)
            $display("FAIL mid_reset: txd=%b ready=%b busy=%b, required txd=1 ready=1 busy=0",
                     txd_w[0], ready_w[0], busy_w[0]);
        else n_pass++;
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 100; i++) begin
            if (txd_w[0] !== 1'b1 || busy_w[0] !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        n_total++;
        if (!ok) $display("FAIL mid_no_resume: txd=%b busy=%b, required txd=1 busy=0 for 100 cycles", txd_w[0], busy_w[0]);
        else n_pass++;
    endtask

    task automatic test_default();
        fork
            send(4, 9'h000);
            monitor(4, 1);
        join
    endtask

    initial begin
        for (int i = 0; i < 5; i++) data_r[i] = '0;
        test_reset();
        test_8n1();
        test_parity();
        test_back_to_back();
        test_reset_mid_frame();
        test_default();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion before 1 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
